fft_frame_scheduler: RTL and testbench

FFT_FRAME_SCHEDULER -- requirements
Module: fft_frame_scheduler

---
 rtl/fft_frame_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler
//
// Sequences one FFT per incoming audio frame and publishes the result to the
// display at the next VGA vertical-blanking boundary, with a peak-hold decay
// on the displayed bins.
//
// Flow: IDLE -> START (launch FFT) -> WAIT_DONE (capture bins or time out)
//       -> HOLD (wait for vsync falling edge) -> COMMIT (update display) -> IDLE
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   new_t      1-cycle pulse: a 16-sample frame is ready
//   start      1-cycle pulse: launch one FFT
//   done       1-cycle pulse: FFT finished, f0..f15 valid this cycle
//   f0..f15    FFT bin magnitudes (unsigned 16-bit)
//   vsync      VGA vertical sync, active-low, synchronous to clk
//   d0..d15    display bins (unsigned 16-bit), stable between commits
//   commit     1-cycle pulse in the cycle the display bins are updated
//   drop_cnt   saturating count of dropped frames (busy or timeout)
//   busy       high whenever the FSM is not in IDLE
//   fsm_state  current FSM state (debug)
//
// Handshake: every control signal is a single-cycle pulse, no back-pressure.
// new_t is only accepted in IDLE; in any other state it is counted as a drop
// and forgotten. done is only honoured in WAIT_DONE. A vsync falling edge is
// only honoured in HOLD.

module fft_frame_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DECAY_SHIFT    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_t,
    output logic        start,
    input  logic        done,
    input  logic [15:0] f0,
    input  logic [15:0] f1,
    input  logic [15:0] f2,
    input  logic [15:0] f3,
    input  logic [15:0] f4,
    input  logic [15:0] f5,
    input  logic [15:0] f6,
    input  logic [15:0] f7,
    input  logic [15:0] f8,
    input  logic [15:0] f9,
    input  logic [15:0] f10,
    input  logic [15:0] f11,
    input  logic [15:0] f12,
    input  logic [15:0] f13,
    input  logic [15:0] f14,
    input  logic [15:0] f15,
    input  logic        vsync,
    output logic [15:0] d0,
    output logic [15:0] d1,
    output logic [15:0] d2,
    output logic [15:0] d3,
    output logic [15:0] d4,
    output logic [15:0] d5,
    output logic [15:0] d6,
    output logic [15:0] d7,
    output logic [15:0] d8,
    output logic [15:0] d9,
    output logic [15:0] d10,
    output logic [15:0] d11,
    output logic [15:0] d12,
    output logic [15:0] d13,
    output logic [15:0] d14,
    output logic [15:0] d15,
    output logic        commit,
    output logic [7:0]  drop_cnt,
    output logic        busy,
    output logic [2:0]  fsm_state
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_DONE = 3'd2,
        HOLD      = 3'd3,
        COMMIT    = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   tcnt;
    logic            vsync_q;
    logic            vsync_fall;
    logic            capture;
    logic            timeout;
    logic            drop_event;
    logic [15:0]     f_in    [16];
    logic [15:0]     stage   [16];
    logic [15:0]     d_reg   [16];
    logic [15:0]     decayed [16];
    logic [15:0]     d_nxt   [16];

    assign f_in[0]  = f0;
    assign f_in[1]  = f1;
    assign f_in[2]  = f2;
    assign f_in[3]  = f3;
    assign f_in[4]  = f4;
    assign f_in[5]  = f5;
    assign f_in[6]  = f6;
    assign f_in[7]  = f7;
    assign f_in[8]  = f8;
    assign f_in[9]  = f9;
    assign f_in[10] = f10;
    assign f_in[11] = f11;
    assign f_in[12] = f12;
    assign f_in[13] = f13;
    assign f_in[14] = f14;
    assign f_in[15] = f15;

    assign d0  = d_reg[0];
    assign d1  = d_reg[1];
    assign d2  = d_reg[2];
    assign d3  = d_reg[3];
    assign d4  = d_reg[4];
    assign d5  = d_reg[5];
    assign d6  = d_reg[6];
    assign d7  = d_reg[7];
    assign d8  = d_reg[8];
    assign d9  = d_reg[9];
    assign d10 = d_reg[10];
    assign d11 = d_reg[11];
    assign d12 = d_reg[12];
    assign d13 = d_reg[13];
    assign d14 = d_reg[14];
    assign d15 = d_reg[15];

    // Falling edge of the active-low vsync: previous sample high, current low.
    assign vsync_fall = vsync_q & ~vsync;

    // Outputs are pure functions of the state register, so each pulse lasts
    // exactly one cycle and can never appear outside its own state.
    assign start     = (state == START);
    assign commit    = (state == COMMIT);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    // A timeout drop and a busy drop in the same cycle count as one drop.
    assign drop_event = timeout | (new_t & (state != IDLE));

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (new_t) state_nxt = START;
            end
            START: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done wins over an expiring timeout in the same cycle.
                if (done) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else if (tcnt == TLAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (vsync_fall) state_nxt = COMMIT;
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Peak hold: each bin decays by d/2^DECAY_SHIFT per commit, which can
    // never exceed d, so the subtraction cannot underflow.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            decayed[k] = d_reg[k] - (d_reg[k] >> DECAY_SHIFT);
            d_nxt[k]   = (stage[k] > decayed[k]) ? stage[k] : decayed[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (state == START) begin
            tcnt <= '0;
        end else if (state == WAIT_DONE) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= 8'd0;
        end else if (drop_event && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 16; k++) begin
                stage[k] <= 16'd0;
                d_reg[k] <= 16'd0;
            end
        end else begin
            if (capture) begin
                for (int k = 0; k < 16; k++) stage[k] <= f_in[k];
            end
            if (state == COMMIT) begin
                for (int k = 0; k < 16; k++) d_reg[k] <= d_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler (default parameters:
// TIMEOUT_CYCLES=4096, DECAY_SHIFT=3). Directed scenarios with hand-computed
// expected values; inputs are driven 1 time unit after each rising edge and
// outputs are sampled at the same point.
`timescale 1ns/1ps

module tb_fft_frame_scheduler;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [14:0] FRAME_TRACE = {S_START, S_WAIT, S_HOLD, S_COMMIT, S_IDLE};

    logic        clk = 1'b0;
    logic        reset;
    logic        new_t;
    logic        done;
    logic        vsync;
    logic [15:0] f [16];
    logic [15:0] d [16];
    logic        start;
    logic        commit;
    logic [7:0]  drop_cnt;
    logic        busy;
    logic [2:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    int start_seen = 0;
    int commit_seen = 0;
    logic [14:0] trace;

    fft_frame_scheduler #(.TIMEOUT_CYCLES(4096), .DECAY_SHIFT(3)) dut (
        .clk(clk), .reset(reset), .new_t(new_t), .start(start), .done(done),
        .f0(f[0]), .f1(f[1]), .f2(f[2]), .f3(f[3]), .f4(f[4]), .f5(f[5]),
        .f6(f[6]), .f7(f[7]), .f8(f[8]), .f9(f[9]), .f10(f[10]), .f11(f[11]),
        .f12(f[12]), .f13(f[13]), .f14(f[14]), .f15(f[15]),
        .vsync(vsync),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .d4(d[4]), .d5(d[5]),
        .d6(d[6]), .d7(d[7]), .d8(d[8]), .d9(d[9]), .d10(d[10]), .d11(d[11]),
        .d12(d[12]), .d13(d[13]), .d14(d[14]), .d15(d[15]),
        .commit(commit), .drop_cnt(drop_cnt), .busy(busy), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start)  start_seen++;
        if (commit) commit_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bins();
        for (int k = 0; k < 16; k++) f[k] = 16'd0;
    endtask

    task automatic enter_wait_done();
        new_t = 1'b1;
        tick();
        new_t = 1'b0;
        tick();
    endtask

    task automatic pulse_done(input int idx, input logic [15:0] val);
        clear_bins();
        f[idx] = val;
        done = 1'b1;
        tick();
        done = 1'b0;
        clear_bins();
    endtask

    task automatic vsync_fall();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
    endtask

    // Full frame with one non-zero bin; returns the state seen at each step.
    task automatic run_frame(input int idx, input logic [15:0] val, output logic [14:0] tr);
        new_t = 1'b1;
        tick();
        tr[14:12] = fsm_state;
        new_t = 1'b0;
        tick();
        tr[11:9] = fsm_state;
        pulse_done(idx, val);
        tr[8:6] = fsm_state;
        tick();
        tick();
        vsync_fall();
        tr[5:3] = fsm_state;
        tick();
        tr[2:0] = fsm_state;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        new_t = 1'b0;
        done  = 1'b0;
        vsync = 1'b1;
        clear_bins();
        tick();
        tick();
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, S_IDLE); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b expected 0", commit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        checks++; if (d[3] !== 16'h0000 || d[15] !== 16'h0000) begin errors++; $display("FAIL reset_d: got d3=%h d15=%h expected 0", d[3], d[15]); end
        reset = 1'b1;
        tick();
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_release_state: got %0d expected %0d", fsm_state, S_IDLE); end
    endtask

    task automatic test_nominal();
        run_frame(3, 16'h1000, trace);
        checks++; if (trace !== FRAME_TRACE) begin errors++; $display("FAIL nominal_trace: got %h expected %h", trace, FRAME_TRACE); end
        checks++; if (d[3] !== 16'h1000) begin errors++; $display("FAIL nominal_d3: got %h expected 1000", d[3]); end
        checks++; if (d[0] !== 16'h0000 || d[15] !== 16'h0000) begin errors++; $display("FAIL nominal_other: got d0=%h d15=%h expected 0", d[0], d[15]); end
        checks++; if (start_seen !== 1) begin errors++; $display("FAIL nominal_starts: got %0d expected 1", start_seen); end
        checks++; if (commit_seen !== 1) begin errors++; $display("FAIL nominal_commits: got %0d expected 1", commit_seen); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL nominal_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_decay();
        run_frame(3, 16'h0000, trace);
        checks++; if (d[3] !== 16'h0E00) begin errors++; $display("FAIL decay_d3_a: got %h expected 0e00", d[3]); end
        run_frame(3, 16'h0F00, trace);
        checks++; if (d[3] !== 16'h0F00) begin errors++; $display("FAIL decay_d3_b: got %h expected 0f00", d[3]); end
        run_frame(15, 16'h8000, trace);
        checks++; if (d[15] !== 16'h8000) begin errors++; $display("FAIL decay_d15_unsigned: got %h expected 8000", d[15]); end
        checks++; if (d[3] !== 16'h0D20) begin errors++; $display("FAIL decay_d3_c: got %h expected 0d20", d[3]); end
        checks++; if (trace !== FRAME_TRACE) begin errors++; $display("FAIL decay_trace: got %h expected %h", trace, FRAME_TRACE); end
    endtask

    task automatic test_ignored();
        f[3] = 16'hFFFF;
        done = 1'b1;
        tick();
        done = 1'b0;
        clear_bins();
        checks++; if (fsm_state !== S_IDLE || busy !== 1'b0) begin errors++; $display("FAIL ignore_done: got state=%0d busy=%b expected 0/0", fsm_state, busy); end
        vsync_fall();
        tick();
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL ignore_vsync_state: got %0d expected %0d", fsm_state, S_IDLE); end
        checks++; if (commit_seen !== 4 || d[3] !== 16'h0D20) begin errors++; $display("FAIL ignore_vsync: got commits=%0d d3=%h expected 4/0d20", commit_seen, d[3]); end
    endtask

    task automatic test_busy_drop();
        enter_wait_done();
        for (int i = 0; i < 3; i++) begin
            new_t = 1'b1;
            tick();
            new_t = 1'b0;
            tick();
        end
        checks++; if (fsm_state !== S_WAIT) begin errors++; $display("FAIL busy_state: got %0d expected %0d", fsm_state, S_WAIT); end
        checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL busy_drop: got %0d expected 3", drop_cnt); end
        pulse_done(5, 16'h0123);
        vsync_fall();
        tick();
        tick();
        checks++; if (d[5] !== 16'h0123 || d[3] !== 16'h0B7C || d[15] !== 16'h7000) begin errors++; $display("FAIL busy_d: got d5=%h d3=%h d15=%h expected 0123/0b7c/7000", d[5], d[3], d[15]); end
        checks++; if (start_seen !== 5 || commit_seen !== 5) begin errors++; $display("FAIL busy_pulses: got starts=%0d commits=%0d expected 5/5", start_seen, commit_seen); end
    endtask

    task automatic test_timeout();
        new_t = 1'b1;
        tick();
        new_t = 1'b0;
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL timeout_start: got %b expected 1", start); end
        repeat (4096) tick();
        checks++; if (fsm_state !== S_WAIT || drop_cnt !== 8'd3) begin errors++; $display("FAIL timeout_early: got state=%0d drop=%0d expected 2/3", fsm_state, drop_cnt); end
        tick();
        checks++; if (fsm_state !== S_IDLE || drop_cnt !== 8'd4) begin errors++; $display("FAIL timeout_expire: got state=%0d drop=%0d expected 0/4", fsm_state, drop_cnt); end
        checks++; if (commit_seen !== 5 || d[3] !== 16'h0B7C || d[5] !== 16'h0123) begin errors++; $display("FAIL timeout_d: got commits=%0d d3=%h d5=%h expected 5/0b7c/0123", commit_seen, d[3], d[5]); end
    endtask

    task automatic test_timeout_and_new_t();
        new_t = 1'b1;
        tick();
        new_t = 1'b0;
        repeat (4096) tick();
        new_t = 1'b1;
        tick();
        new_t = 1'b0;
        checks++; if (fsm_state !== S_IDLE || drop_cnt !== 8'd5) begin errors++; $display("FAIL double_drop: got state=%0d drop=%0d expected 0/5", fsm_state, drop_cnt); end
        tick();
        checks++; if (fsm_state !== S_IDLE || start_seen !== 7) begin errors++; $display("FAIL double_not_queued: got state=%0d starts=%0d expected 0/7", fsm_state, start_seen); end
    endtask

    task automatic test_done_at_timeout();
        new_t = 1'b1;
        tick();
        new_t = 1'b0;
        repeat (4096) tick();
        pulse_done(7, 16'h0777);
        checks++; if (fsm_state !== S_HOLD || drop_cnt !== 8'd5) begin errors++; $display("FAIL done_priority: got state=%0d drop=%0d expected 3/5", fsm_state, drop_cnt); end
        vsync_fall();
        tick();
        checks++; if (d[7] !== 16'h0777 || d[3] !== 16'h0A0D || d[5] !== 16'h00FF) begin errors++; $display("FAIL done_priority_d: got d7=%h d3=%h d5=%h expected 0777/0a0d/00ff", d[7], d[3], d[5]); end
    endtask

    task automatic test_saturation();
        enter_wait_done();
        new_t = 1'b1;
        repeat (249) tick();
        checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", drop_cnt); end
        repeat (51) tick();
        new_t = 1'b0;
        checks++; if (drop_cnt !== 8'd255 || fsm_state !== S_WAIT) begin errors++; $display("FAIL sat_255: got drop=%0d state=%0d expected 255/2", drop_cnt, fsm_state); end
        pulse_done(0, 16'hFFFF);
        vsync_fall();
        tick();
        checks++; if (d[0] !== 16'hFFFF || drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_frame: got d0=%h drop=%0d expected ffff/255", d[0], drop_cnt); end
    endtask

    task automatic test_reset_mid_hold();
        enter_wait_done();
        pulse_done(2, 16'h2222);
        checks++; if (fsm_state !== S_HOLD) begin errors++; $display("FAIL rst_hold_entry: got %0d expected %0d", fsm_state, S_HOLD); end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || fsm_state !== S_IDLE || drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_async: got busy=%b state=%0d drop=%0d expected 0/0/0", busy, fsm_state, drop_cnt); end
        checks++; if (d[0] !== 16'h0000 || d[7] !== 16'h0000) begin errors++; $display("FAIL rst_d: got d0=%h d7=%h expected 0", d[0], d[7]); end
        tick();
        reset = 1'b1;
        vsync_fall();
        tick();
        checks++; if (commit_seen !== 7 || d[2] !== 16'h0000 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_commit: got commits=%0d d2=%h busy=%b expected 7/0000/0", commit_seen, d[2], busy); end
        run_frame(2, 16'h0042, trace);
        checks++; if (trace !== FRAME_TRACE || d[2] !== 16'h0042) begin errors++; $display("FAIL rst_first_frame: got trace=%h d2=%h expected %h/0042", trace, d[2], FRAME_TRACE); end
        checks++; if (start_seen !== 11 || commit_seen !== 8) begin errors++; $display("FAIL rst_pulses: got starts=%0d commits=%0d expected 11/8", start_seen, commit_seen); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_nominal();
        test_decay();
        test_ignored();
        test_busy_drop();
        test_timeout();
        test_timeout_and_new_t();
        test_done_at_timeout();
        test_saturation();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
